// File: rtl/pixel_collector.sv
// pixel_collector
//   Drains result bytes from NUM_SOLVERS row-interleaved pattern solvers and
//   writes them to a frame buffer. Solver k owns rows k, k+N, k+2N, ... and
//   produces each row left to right. The collector tracks every solver's
//   pixel position, grants ready solvers round-robin, and presents one pixel
//   per cycle on a valid/ready write port with a linear address.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   solver_out          result byte of solver k on bits [8k+7:8k]
//   solver_ready        solver k holds a valid byte until its continue pulse
//   solver_done         solver k has finished its rows (level)
//   solver_continue     one-cycle release pulse to solver k (combinational)
//   pix_valid/pix_ready write handshake towards the frame buffer
//   pix_addr, pix_data  row*WIDTH + col, pixel value
//   frame_done          every pixel of the frame written (sticky)
//   overflow            a solver produced a pixel beyond HEIGHT (sticky)
//
// The release output is named solver_continue because "continue" is a
// reserved word in SystemVerilog.

module pixel_collector #(
    parameter int unsigned NUM_SOLVERS = 4,
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned ADDR_W      = 19
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [8*NUM_SOLVERS-1:0] solver_out,
    input  logic [NUM_SOLVERS-1:0]   solver_ready,
    input  logic [NUM_SOLVERS-1:0]   solver_done,
    output logic [NUM_SOLVERS-1:0]   solver_continue,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [ADDR_W-1:0]        pix_addr,
    output logic [7:0]               pix_data,
    output logic                     frame_done,
    output logic                     overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Row counters must reach HEIGHT-1+N after the final row wrap.
    localparam int unsigned RW = $clog2(HEIGHT + NUM_SOLVERS + 1);
    localparam int unsigned PW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

    localparam logic [CW-1:0]     COL_LAST  = CW'(WIDTH - 1);
    localparam logic [RW-1:0]     ROW_LIMIT = RW'(HEIGHT);
    localparam logic [RW-1:0]     ROW_STEP  = RW'(NUM_SOLVERS);
    localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(NUM_SOLVERS * WIDTH);
    localparam logic [PW-1:0]     PTR_LAST  = PW'(NUM_SOLVERS - 1);

    // Per-solver position; base_q tracks row_q*WIDTH so no multiplier is needed.
    logic [CW-1:0]     col_q  [NUM_SOLVERS];
    logic [CW-1:0]     col_d  [NUM_SOLVERS];
    logic [RW-1:0]     row_q  [NUM_SOLVERS];
    logic [RW-1:0]     row_d  [NUM_SOLVERS];
    logic [ADDR_W-1:0] base_q [NUM_SOLVERS];
    logic [ADDR_W-1:0] base_d [NUM_SOLVERS];

    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              pix_valid_q, pix_valid_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [7:0]        pix_data_q, pix_data_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic                   stage_free;
    logic                   gnt_any;
    logic [PW-1:0]          gnt_idx;
    logic [NUM_SOLVERS-1:0] grant;
    logic                   all_rows_done;
    int unsigned            scan_idx;

    // Round-robin search starting at rr_ptr_q, wrapping at NUM_SOLVERS.
    always_comb begin
        stage_free    = !pix_valid_q || pix_ready;
        gnt_any       = 1'b0;
        gnt_idx       = '0;
        grant         = '0;
        scan_idx      = 0;
        all_rows_done = 1'b1;
        for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= NUM_SOLVERS) begin
                scan_idx = scan_idx - NUM_SOLVERS;
            end
            if (stage_free && !gnt_any && solver_ready[scan_idx]) begin
                gnt_any         = 1'b1;
                gnt_idx         = PW'(scan_idx);
                grant[scan_idx] = 1'b1;
            end
        end
        for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
            if (row_q[k] < ROW_LIMIT) begin
                all_rows_done = 1'b0;
            end
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        base_d       = base_q;
        rr_ptr_d     = rr_ptr_q;
        pix_valid_d  = pix_valid_q;
        pix_addr_d   = pix_addr_q;
        pix_data_d   = pix_data_q;
        frame_done_d = frame_done_q;
        overflow_d   = overflow_q;

        if (pix_valid_q && pix_ready) begin
            pix_valid_d = 1'b0;
        end

        if (gnt_any) begin
            if (row_q[gnt_idx] < ROW_LIMIT) begin
                pix_valid_d = 1'b1;
                pix_data_d  = solver_out[8*gnt_idx +: 8];
                pix_addr_d  = base_q[gnt_idx] + ADDR_W'(col_q[gnt_idx]);
                if (col_q[gnt_idx] == COL_LAST) begin
                    col_d[gnt_idx]  = '0;
                    row_d[gnt_idx]  = row_q[gnt_idx] + ROW_STEP;
                    base_d[gnt_idx] = base_q[gnt_idx] + BASE_STEP;
                end else begin
                    col_d[gnt_idx] = col_q[gnt_idx] + 1'b1;
                end
                rr_ptr_d = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
            end else begin
                // Byte past the last row: released and dropped, position frozen.
                overflow_d = 1'b1;
            end
        end

        if ((&solver_done) && !(|solver_ready) && stage_free && all_rows_done) begin
            frame_done_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
                col_q[k]  <= '0;
                row_q[k]  <= RW'(k);
                base_q[k] <= ADDR_W'(k * WIDTH);
            end
            rr_ptr_q     <= '0;
            pix_valid_q  <= 1'b0;
            pix_addr_q   <= '0;
            pix_data_q   <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            base_q       <= base_d;
            rr_ptr_q     <= rr_ptr_d;
            pix_valid_q  <= pix_valid_d;
            pix_addr_q   <= pix_addr_d;
            pix_data_q   <= pix_data_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign solver_continue = grant;
    assign pix_valid       = pix_valid_q;
    assign pix_addr        = pix_addr_q;
    assign pix_data        = pix_data_q;
    assign frame_done      = frame_done_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_pixel_collector.sv
// Directed bench for pixel_collector: four instances with small frame
// geometries cover sequential writes, round-robin interleave, backpressure,
// pointer wrap, overflow, short frame and mid-frame reset.

module tb_pixel_collector;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // A: N=1, 4x2
    logic [7:0]  a_out;
    logic [0:0]  a_rdy, a_done, a_cont;
    logic        a_pv, a_pr, a_fd, a_ov;
    logic [2:0]  a_addr;
    logic [7:0]  a_data;
    // B: N=2, 3x4
    logic [15:0] b_out;
    logic [1:0]  b_rdy, b_done, b_cont;
    logic        b_pv, b_pr, b_fd, b_ov;
    logic [3:0]  b_addr;
    logic [7:0]  b_data;
    // C: N=4, 4x8
    logic [31:0] c_out;
    logic [3:0]  c_rdy, c_done, c_cont;
    logic        c_pv, c_pr, c_fd, c_ov;
    logic [4:0]  c_addr;
    logic [7:0]  c_data;
    // D: N=2, 2x2
    logic [15:0] d_out;
    logic [1:0]  d_rdy, d_done, d_cont;
    logic        d_pv, d_pr, d_fd, d_ov;
    logic [1:0]  d_addr;
    logic [7:0]  d_data;

    pixel_collector #(.NUM_SOLVERS(1), .WIDTH(4), .HEIGHT(2), .ADDR_W(3)) u_a (
        .clock(clock), .reset(reset), .solver_out(a_out), .solver_ready(a_rdy),
        .solver_done(a_done), .solver_continue(a_cont), .pix_valid(a_pv),
        .pix_ready(a_pr), .pix_addr(a_addr), .pix_data(a_data),
        .frame_done(a_fd), .overflow(a_ov));

    pixel_collector #(.NUM_SOLVERS(2), .WIDTH(3), .HEIGHT(4), .ADDR_W(4)) u_b (
        .clock(clock), .reset(reset), .solver_out(b_out), .solver_ready(b_rdy),
        .solver_done(b_done), .solver_continue(b_cont), .pix_valid(b_pv),
        .pix_ready(b_pr), .pix_addr(b_addr), .pix_data(b_data),
        .frame_done(b_fd), .overflow(b_ov));

    pixel_collector #(.NUM_SOLVERS(4), .WIDTH(4), .HEIGHT(8), .ADDR_W(5)) u_c (
        .clock(clock), .reset(reset), .solver_out(c_out), .solver_ready(c_rdy),
        .solver_done(c_done), .solver_continue(c_cont), .pix_valid(c_pv),
        .pix_ready(c_pr), .pix_addr(c_addr), .pix_data(c_data),
        .frame_done(c_fd), .overflow(c_ov));

    pixel_collector #(.NUM_SOLVERS(2), .WIDTH(2), .HEIGHT(2), .ADDR_W(2)) u_d (
        .clock(clock), .reset(reset), .solver_out(d_out), .solver_ready(d_rdy),
        .solver_done(d_done), .solver_continue(d_cont), .pix_valid(d_pv),
        .pix_ready(d_pr), .pix_addr(d_addr), .pix_data(d_data),
        .frame_done(d_fd), .overflow(d_ov));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string name, input logic pv, input logic [31:0] addr,
                             input logic [31:0] data, input logic fd, input logic ov,
                             input logic [31:0] cont);
        chk({name, " rst pix_valid"}, 32'(pv), 0);
        chk({name, " rst pix_addr"}, addr, 0);
        chk({name, " rst pix_data"}, data, 0);
        chk({name, " rst frame_done"}, 32'(fd), 0);
        chk({name, " rst overflow"}, 32'(ov), 0);
        chk({name, " rst continue"}, cont, 0);
    endtask

    // Sample point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int exp_b [12] = '{0, 3, 1, 4, 2, 5, 6, 9, 7, 10, 8, 11};

    initial begin
        reset = 1'b1;
        a_out = '0; a_rdy = '0; a_done = '0; a_pr = 1'b1;
        b_out = '0; b_rdy = '0; b_done = '0; b_pr = 1'b1;
        c_out = '0; c_rdy = '0; c_done = '0; c_pr = 1'b1;
        d_out = '0; d_rdy = '0; d_done = '0; d_pr = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk_reset("A", a_pv, 32'(a_addr), 32'(a_data), a_fd, a_ov, 32'(a_cont));
        chk_reset("B", b_pv, 32'(b_addr), 32'(b_data), b_fd, b_ov, 32'(b_cont));
        chk_reset("C", c_pv, 32'(c_addr), 32'(c_data), c_fd, c_ov, 32'(c_cont));
        chk_reset("D", d_pv, 32'(d_addr), 32'(d_data), d_fd, d_ov, 32'(d_cont));
        reset = 1'b0;

        // A: one solver, 8 pixels 0x10..0x17 to addresses 0..7
        a_rdy = 1'b1;
        a_out = 8'h10;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("A continue", 32'(a_cont), 1);
            tick();
            chk("A pix_valid", 32'(a_pv), 1);
            chk("A pix_addr", 32'(a_addr), 32'(i));
            chk("A pix_data", 32'(a_data), 32'(8'h10 + i));
            chk("A frame_done early", 32'(a_fd), 0);
            if (i == 7) begin
                a_rdy  = 1'b0;
                a_done = 1'b1;
            end else begin
                a_out = 8'(8'h11 + i);
            end
            #1;
        end
        chk("A continue idle", 32'(a_cont), 0);
        tick();
        chk("A drained", 32'(a_pv), 0);
        chk("A frame_done", 32'(a_fd), 1);
        chk("A overflow", 32'(a_ov), 0);
        a_done = 1'b0;
        tick();
        chk("A frame_done sticky", 32'(a_fd), 1);

        // A: async reset while a pixel is held under backpressure
        reset = 1'b1;
        #1;
        reset = 1'b0;
        a_rdy = 1'b1;
        a_out = 8'h21;
        #1;
        chk("R continue", 32'(a_cont), 1);
        tick();
        chk("R pix_valid", 32'(a_pv), 1);
        chk("R pix_addr", 32'(a_addr), 0);
        a_rdy = 1'b0;
        a_pr  = 1'b0;
        tick();
        chk("R held valid", 32'(a_pv), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("R async pix_valid", 32'(a_pv), 0);
        chk("R async pix_data", 32'(a_data), 0);
        chk("R async frame_done", 32'(a_fd), 0);
        #1;
        reset = 1'b0;
        a_pr  = 1'b1;
        a_rdy = 1'b1;
        a_out = 8'h33;
        #1;
        chk("R continue after", 32'(a_cont), 1);
        tick();
        chk("R first pix_valid", 32'(a_pv), 1);
        chk("R first pix_addr", 32'(a_addr), 0);
        chk("R first pix_data", 32'(a_data), 32'h33);
        a_rdy = 1'b0;
        tick();

        // B: two always-ready solvers interleave round-robin
        b_rdy = 2'b11;
        b_out = {8'h41, 8'h40};
        #1;
        for (int i = 0; i < 12; i++) begin
            chk("B continue", 32'(b_cont), (i % 2 == 0) ? 1 : 2);
            tick();
            chk("B pix_valid", 32'(b_pv), 1);
            chk("B pix_addr", 32'(b_addr), 32'(exp_b[i]));
            chk("B pix_data", 32'(b_data), 32'(8'h40 + (i % 2)));
            if (i == 10) b_rdy = 2'b10;
            if (i == 11) begin
                b_rdy  = 2'b00;
                b_done = 2'b11;
            end
            #1;
        end
        chk("B continue idle", 32'(b_cont), 0);
        tick();
        chk("B drained", 32'(b_pv), 0);
        chk("B frame_done", 32'(b_fd), 1);
        chk("B overflow", 32'(b_ov), 0);

        // C: backpressure, all solvers ready
        reset = 1'b1;
        #1;
        reset = 1'b0;
        c_rdy = 4'hF;
        c_out = {8'h83, 8'h82, 8'h81, 8'h80};
        #1;
        chk("C continue first", 32'(c_cont), 1);
        tick();
        chk("C pix_addr first", 32'(c_addr), 0);
        c_rdy = 4'hE;
        c_pr  = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("C stall continue", 32'(c_cont), 0);
            tick();
            chk("C stall pix_valid", 32'(c_pv), 1);
            chk("C stall pix_addr", 32'(c_addr), 0);
            chk("C stall pix_data", 32'(c_data), 32'h80);
        end
        c_pr = 1'b1;
        #1;
        chk("C resume continue", 32'(c_cont), 2);
        tick();
        chk("C resume pix_addr", 32'(c_addr), 4);
        chk("C resume pix_data", 32'(c_data), 32'h81);
        c_rdy = 4'h0;
        tick();
        chk("C drained", 32'(c_pv), 0);

        // C: pointer advance and wrap
        reset = 1'b1;
        #1;
        reset = 1'b0;
        c_rdy = 4'b0100;
        #1;
        chk("C rr only2", 32'(c_cont), 4);
        tick();
        chk("C rr addr2", 32'(c_addr), 8);
        chk("C rr data2", 32'(c_data), 32'h82);
        c_rdy = 4'b0101;
        #1;
        chk("C rr wrap0", 32'(c_cont), 1);
        tick();
        chk("C rr addr0", 32'(c_addr), 0);
        chk("C rr data0", 32'(c_data), 32'h80);
        c_rdy = 4'b0100;
        #1;
        chk("C rr again2", 32'(c_cont), 4);
        tick();
        chk("C rr addr2b", 32'(c_addr), 9);
        c_rdy = 4'b0000;
        tick();

        // D: third pixel from solver 0 overflows; then short frame
        reset = 1'b1;
        #1;
        reset = 1'b0;
        d_rdy = 2'b01;
        d_out = {8'h00, 8'h55};
        #1;
        chk("D continue p0", 32'(d_cont), 1);
        tick();
        chk("D pix_addr p0", 32'(d_addr), 0);
        chk("D pix_data p0", 32'(d_data), 32'h55);
        d_out = {8'h00, 8'h56};
        #1;
        chk("D continue p1", 32'(d_cont), 1);
        tick();
        chk("D pix_addr p1", 32'(d_addr), 1);
        chk("D pix_data p1", 32'(d_data), 32'h56);
        d_out = {8'h00, 8'h57};
        #1;
        chk("D continue ovf", 32'(d_cont), 1);
        tick();
        chk("D ovf pix_valid", 32'(d_pv), 0);
        chk("D ovf flag", 32'(d_ov), 1);
        chk("D ovf pix_data", 32'(d_data), 32'h56);
        d_rdy  = 2'b00;
        d_done = 2'b11;
        #1;
        chk("D continue idle", 32'(d_cont), 0);
        tick();
        chk("D ovf sticky", 32'(d_ov), 1);
        tick();
        chk("D short frame", 32'(d_fd), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_collector.md
Name: pixel_collector

Overview:
- Consumer end of the solver interface: drains result bytes from NUM_SOLVERS row-interleaved pattern solvers and writes them to the frame buffer.
- Solver k owns rows k, k+N, k+2N, …; within its row it produces pixels left to right.
- Tracks each solver's current pixel position, arbitrates round-robin among ready solvers, and issues the per-solver continue pulse that releases the next pixel.
- Presents one pixel per cycle on a valid/ready write port carrying a linear frame-buffer address.

Parameters:
NUM_SOLVERS, 4, number of solvers (N), 1..16
WIDTH, 640, pixels per row
HEIGHT, 480, rows per frame
ADDR_W, 19, frame-buffer address width; must satisfy WIDTH*HEIGHT <= 2^ADDR_W

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
solver_out  in  8*NUM_SOLVERS  result byte of solver k on bits [8k+7:8k]
solver_ready  in  NUM_SOLVERS  solver k holds a valid byte; held until its continue
solver_done  in  NUM_SOLVERS  solver k has finished its rows; level
continue  out  NUM_SOLVERS  one-cycle release pulse to solver k
pix_valid  out  1  pix_addr/pix_data valid
pix_ready  in  1  frame buffer accepts the pixel this cycle
pix_addr  out  ADDR_W  row*WIDTH + col
pix_data  out  8  pixel value
frame_done  out  1  all pixels written; sticky
overflow  out  1  a solver produced a pixel beyond HEIGHT; sticky

Behaviour:
- Reset is asynchronous on assertion.
  - Outputs go to: pix_valid=0, pix_addr=0, pix_data=0, frame_done=0, overflow=0, continue=0.
  - Per-solver state goes to: col_k=0, row_k=k, rr_ptr=0.
- Output stage: a single register, treated as free when pix_valid=0 or (pix_valid & pix_ready).
- Grant:
  - When the output stage is free, select the first k with solver_ready[k]=1, searching from rr_ptr upward with wrap.
  - At most one grant per cycle.
- continue:
  - continue[k] is combinational and equals grant[k] in the same cycle.
  - Solver k must drop ready the following cycle.
  - Non-granted solvers keep ready high and receive no pulse.
- On grant of k with row_k < HEIGHT (registered, lands next edge):
  - pix_valid <= 1
  - pix_data <= solver_out[k]
  - pix_addr <= row_k*WIDTH + col_k, computed in ADDR_W bits
  - col_k <= col_k+1
  - When col_k == WIDTH-1: col_k <= 0 and row_k <= row_k+N.
  - rr_ptr <= (k+1) mod N
- On grant of k with row_k >= HEIGHT:
  - continue is still pulsed and the byte is discarded.
  - overflow <= 1; pix_valid is not loaded; counters are unchanged.
- Hold rule: while pix_valid=1 and pix_ready=0, pix_addr and pix_data hold and no grant occurs.
- Drain with no new grant: pix_valid <= 0.
- Latency:
  - Grant at edge t means pix_valid is high after edge t+1.
  - Back-to-back transfers are possible at 1 pixel/cycle.
- Address arithmetic:
  - Keep a per-solver row-base register (row_k*WIDTH), incremented by N*WIDTH on row wrap.
  - No run-time multiplier.
- frame_done is set (sticky) when all of these hold:
  - all solver_done bits = 1
  - no solver_ready bit is set
  - output stage empty, or draining this cycle
  - every row_k >= HEIGHT
- frame_done never deasserts except by reset.
- If solver_done is all-1 while some row_k < HEIGHT, frame_done stays 0 (short frame; flagged by the bench).
- A reset mid-frame abandons the pending output; pix_valid drops immediately with no partial write.

Test Plan:
- N=1, WIDTH=4, HEIGHT=2, pix_ready=1, solver supplies 0x10..0x17 → addresses 0..7 in order with matching data, 8 continue pulses, frame_done after last write, overflow=0.
- N=2, WIDTH=3, HEIGHT=4, both solvers always ready, data = 0x40+k → round-robin alternation.
  - Solver0 writes addresses 0,1,2,6,7,8; solver1 writes 3,4,5,9,10,11.
  - 12 writes total, one per cycle.
- Backpressure: pix_ready held 0 for 5 cycles with all solvers ready → pix_addr/pix_data stable, continue all 0 throughout; first grant in the cycle pix_ready returns high.
- N=4, only solver 2 ready → grant to 2, then rr_ptr=3; solvers 0 and 2 then ready together → solver 0 granted first (search from 3 wraps to 0).
- Overflow: N=2, HEIGHT=2, WIDTH=2, solver0 supplies a 3rd pixel → continue[0] pulses, no pix_valid, overflow=1 sticky.
- Async reset asserted mid-transfer with pix_valid=1 → pix_valid=0 before the next edge; after release, first write goes to address 0 for solver 0.
